cdb_arb: RTL and testbench

CDB_ARB -- requirements
Module: cdb_arb

---
 rtl/cdb_arb_pkg.sv | 33 +++
 rtl/cdb_arb_src_fifo.sv | 61 ++++++
 rtl/cdb_arb.sv | 100 ++++++++++
 tb/tb_cdb_arb.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arb_pkg.sv
// Shared CDB/ROB packet types and FU-count defaults used by the CDB arbiter slice.
// Also carries the sys_defs macros (NUM_FU_*, CDB_SZ) so the parameter defaults resolve.
`ifndef NUM_FU_ALU
`define NUM_FU_ALU 2
`endif
`ifndef NUM_FU_MULT
`define NUM_FU_MULT 1
`endif
`ifndef NUM_FU_LOAD
`define NUM_FU_LOAD 1
`endif
`ifndef CDB_SZ
`define CDB_SZ 2
`endif

package cdb_arb_pkg;
  localparam int PRN_W = 6;
  localparam int ROB_W = 5;

  typedef struct packed {
    logic [PRN_W-1:0] dest_prn;
    logic [31:0]      value;
  } CDB_PACKET;

  typedef struct packed {
    logic [ROB_W-1:0] robn;
    logic             executed;
    logic             branch_taken;
    logic [31:0]      target_addr;
  } FU_ROB_PACKET;

  typedef logic [$clog2(`NUM_FU_ALU + `NUM_FU_MULT + `NUM_FU_LOAD)-1:0] CDB_ARB_SRC_IDX;
endpackage

// File: rtl/cdb_arb_src_fifo.sv
// Per-source result FIFO (cdb_src_fifo): ready means not full at cycle start, no bypass.
module cdb_src_fifo
  import cdb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  CDB_PACKET    push_cdb,
  input  FU_ROB_PACKET push_rob,
  input  logic         pop,
  output logic         ready,
  output logic         not_empty,
  output CDB_PACKET    head_cdb,
  output FU_ROB_PACKET head_rob
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  CDB_PACKET    cdb_mem [DEPTH];
  FU_ROB_PACKET rob_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ready     = (count < CNT_W'(DEPTH));
  assign not_empty = (count != '0);
  assign do_push   = push && ready;
  assign do_pop    = pop && not_empty;
  assign head_cdb  = cdb_mem[rd_ptr];
  assign head_rob  = rob_mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      cdb_mem[wr_ptr] <= push_cdb;
      rob_mem[wr_ptr] <= push_rob;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/cdb_arb.sv
// CDB arbiter: per-source FIFOs, up to NUM_CH grants per cycle, registered broadcast.
// Define CDB_ARB_RR_EN for rotating priority; default is fixed lowest-index-first.
module cdb_arb
  import cdb_arb_pkg::*;
#(
  parameter int NUM_SRC = `NUM_FU_ALU + `NUM_FU_MULT + `NUM_FU_LOAD,
  parameter int NUM_CH  = `CDB_SZ,
  parameter int DEPTH   = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               squash,
  input  logic [NUM_SRC-1:0] src_valid,
  input  CDB_PACKET          src_cdb       [NUM_SRC],
  input  FU_ROB_PACKET       src_rob       [NUM_SRC],
  output logic [NUM_SRC-1:0] src_ready,
  output logic [NUM_CH-1:0]  cdb_valid,
  output CDB_PACKET          cdb_output    [NUM_CH],
  output FU_ROB_PACKET       fu_rob_packet [NUM_CH]
);
  logic [NUM_SRC-1:0] head_valid, grant;
  CDB_PACKET          head_cdb [NUM_SRC];
  FU_ROB_PACKET       head_rob [NUM_SRC];
  logic [NUM_CH-1:0]  nxt_valid;
  CDB_PACKET          nxt_cdb [NUM_CH];
  FU_ROB_PACKET       nxt_rob [NUM_CH];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    cdb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (squash),
      .push      (src_valid[i]),
      .push_cdb  (src_cdb[i]),
      .push_rob  (src_rob[i]),
      .pop       (grant[i]),
      .ready     (src_ready[i]),
      .not_empty (head_valid[i]),
      .head_cdb  (head_cdb[i]),
      .head_rob  (head_rob[i])
    );
  end

`ifdef CDB_ARB_RR_EN
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  logic [IDX_W-1:0] prio_ptr, ptr_nxt;

  // Pointer holds through squash since that cycle's grants never take effect.
  always_ff @(posedge clock) begin
    if (reset)        prio_ptr <= '0;
    else if (!squash) prio_ptr <= ptr_nxt;
  end
`endif

  always_comb begin
    int unsigned n, idx, start;
    grant     = '0;
    nxt_valid = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      nxt_cdb[c] = '0;
      nxt_rob[c] = '0;
    end
    n = 0;
`ifdef CDB_ARB_RR_EN
    start   = 32'(prio_ptr);
    ptr_nxt = prio_ptr;
`else
    start = 0;
`endif
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = start + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (head_valid[idx] && (n < NUM_CH)) begin
        grant[idx]            = 1'b1;
        nxt_valid[n]          = 1'b1;
        nxt_cdb[n]            = head_cdb[idx];
        nxt_rob[n]            = head_rob[idx];
        nxt_rob[n].executed   = 1'b1;
`ifdef CDB_ARB_RR_EN
        ptr_nxt = (idx + 1 == NUM_SRC) ? '0 : IDX_W'(idx + 1);
`endif
        n = n + 1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || squash) begin
      cdb_valid <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        cdb_output[c]    <= '0;
        fu_rob_packet[c] <= '0;
      end
    end else begin
      cdb_valid     <= nxt_valid;
      cdb_output    <= nxt_cdb;
      fu_rob_packet <= nxt_rob;
    end
  end
endmodule

// File: tb/tb_cdb_arb.sv
// Directed bench for cdb_arb (4 sources, 2 channels, depth 2) with a scoreboard monitor.
module tb_cdb_arb;
  import cdb_arb_pkg::*;

  logic         clock = 1'b0;
  logic         reset, squash;
  logic [3:0]   src_valid;
  CDB_PACKET    src_cdb [4];
  FU_ROB_PACKET src_rob [4];
  logic [3:0]   src_ready;
  logic [1:0]   cdb_valid;
  CDB_PACKET    cdb_output [2];
  FU_ROB_PACKET fu_rob_packet [2];

  cdb_arb #(.NUM_SRC(4), .NUM_CH(2), .DEPTH(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .squash        (squash),
    .src_valid     (src_valid),
    .src_cdb       (src_cdb),
    .src_rob       (src_rob),
    .src_ready     (src_ready),
    .cdb_valid     (cdb_valid),
    .cdb_output    (cdb_output),
    .fu_rob_packet (fu_rob_packet)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    int          ch;
    logic [31:0] v;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          cyc = 0;
  int          k;
  int          total = 0;
  int          bad = 0;
  logic        mon_en = 1'b0;
  logic [3:0]  acc;
  logic [31:0] pend [4][8];
  int          ph [4];
  int          pt [4];

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] val(input int scen, input int src, input int seq);
    return 32'h5000_0000 | 32'(scen << 16) | 32'(src << 8) | 32'(seq);
  endfunction

  function automatic CDB_PACKET mk_cdb(input logic [31:0] v);
    CDB_PACKET r;
    r.dest_prn = v[PRN_W-1:0] ^ 6'h2a;
    r.value    = v;
    return r;
  endfunction

  // Sources always offer executed=0; the arbiter must present executed=1.
  function automatic FU_ROB_PACKET mk_rob(input logic [31:0] v, input logic exec);
    FU_ROB_PACKET r;
    r.robn         = v[ROB_W-1:0] ^ 5'h13;
    r.executed     = exec;
    r.branch_taken = v[0];
    r.target_addr  = ~v;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, req);
    end
  endtask

  task automatic load(input int src, input int n, input int scen);
    for (int s = 0; s < n; s++) begin
      pend[src][pt[src] % 8] = val(scen, src, s);
      pt[src]++;
    end
  endtask

  task automatic ex(input int dk, input int ch, input int scen, input int src, input int seq);
    exp_t x;
    x.cyc = k + dk;
    x.ch  = ch;
    x.v   = val(scen, src, seq);
    sb.push_back(x);
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (ph[i] != pt[i]) begin
        src_valid[i] = 1'b1;
        src_cdb[i]   = mk_cdb(pend[i][ph[i] % 8]);
        src_rob[i]   = mk_rob(pend[i][ph[i] % 8], 1'b0);
      end else begin
        src_valid[i] = 1'b0;
        src_cdb[i]   = '0;
        src_rob[i]   = '0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clock);
    acc = src_valid & src_ready;
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) ph[i]++;
    drive();
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      for (int c = 0; c < 2; c++) begin
        total++;
        if (cdb_valid[c] === 1'b1) begin
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_out cyc=%0d ch=%0d got=%h want=none", cyc, c, cdb_output[c].value);
          end else begin
            e = sb.pop_front();
            if (cyc != e.cyc || c != e.ch || cdb_output[c] !== mk_cdb(e.v) ||
                fu_rob_packet[c] !== mk_rob(e.v, 1'b1)) begin
              bad++;
              $display("FAIL out cyc=%0d ch=%0d got=%h/%h want cyc=%0d ch=%0d %h/%h",
                       cyc, c, cdb_output[c], fu_rob_packet[c], e.cyc, e.ch,
                       mk_cdb(e.v), mk_rob(e.v, 1'b1));
            end
          end
        end else if (cdb_valid[c] !== 1'b0 || cdb_output[c] !== '0 || fu_rob_packet[c] !== '0) begin
          bad++;
          $display("FAIL idle_zero cyc=%0d ch=%0d got v=%b %h/%h want 0", cyc, c,
                   cdb_valid[c], cdb_output[c], fu_rob_packet[c]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    squash = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ph[i] = 0;
      pt[i] = 0;
    end
    drive();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("reset_ready", 32'(src_ready), 32'hf);
    chk("reset_valid", 32'(cdb_valid), 32'h0);
    mon_en = 1'b1;
    tick();

    // Sources 0,1,3 together: two channels, source 3 one cycle later.
    load(0, 1, 1); load(1, 1, 1); load(3, 1, 1); drive(); k = cyc;
    ex(2, 0, 1, 0, 0); ex(2, 1, 1, 1, 0); ex(3, 0, 1, 3, 0);
    repeat (6) tick();

`ifndef CDB_ARB_RR_EN
    // Source 2 backs up behind sources 0 and 1; third offer waits for a free slot.
    load(0, 3, 2); load(1, 3, 2); load(2, 3, 2); drive(); k = cyc;
    ex(2, 0, 2, 0, 0); ex(2, 1, 2, 1, 0); ex(3, 0, 2, 0, 1); ex(3, 1, 2, 1, 1);
    ex(4, 0, 2, 0, 2); ex(4, 1, 2, 1, 2); ex(5, 0, 2, 2, 0); ex(6, 0, 2, 2, 1);
    ex(7, 0, 2, 2, 2);
    tick();
    chk("ready2_one_entry", 32'(src_ready[2]), 32'h1);
    tick();
    chk("ready2_full", 32'(src_ready[2]), 32'h0);
    tick(); tick();
    chk("ready2_deq_cycle", 32'(src_ready[2]), 32'h0);
    tick();
    chk("ready2_after_deq", 32'(src_ready[2]), 32'h1);
    repeat (6) tick();
`endif

    // All four sources continuously offering three results each.
    load(0, 3, 3); load(1, 3, 3); load(2, 3, 3); load(3, 3, 3); drive(); k = cyc;
`ifdef CDB_ARB_RR_EN
    ex(2, 0, 3, 0, 0); ex(2, 1, 3, 1, 0); ex(3, 0, 3, 2, 0); ex(3, 1, 3, 3, 0);
    ex(4, 0, 3, 0, 1); ex(4, 1, 3, 1, 1); ex(5, 0, 3, 2, 1); ex(5, 1, 3, 3, 1);
    ex(6, 0, 3, 0, 2); ex(6, 1, 3, 1, 2); ex(7, 0, 3, 2, 2); ex(7, 1, 3, 3, 2);
`else
    ex(2, 0, 3, 0, 0); ex(2, 1, 3, 1, 0); ex(3, 0, 3, 0, 1); ex(3, 1, 3, 1, 1);
    ex(4, 0, 3, 0, 2); ex(4, 1, 3, 1, 2); ex(5, 0, 3, 2, 0); ex(5, 1, 3, 3, 0);
    ex(6, 0, 3, 2, 1); ex(6, 1, 3, 3, 1); ex(7, 0, 3, 2, 2); ex(7, 1, 3, 3, 2);
`endif
    repeat (9) tick();

    // Squash with three buffered results plus a new offer: nothing may emerge.
    load(0, 1, 4); load(1, 1, 4); load(2, 1, 4); drive();
    tick();
    squash = 1'b1;
    load(3, 1, 4); drive();
    tick();
    squash = 1'b0;
    chk("squash_valid", 32'(cdb_valid), 32'h0);
    chk("squash_ready", 32'(src_ready), 32'hf);
    repeat (5) tick();

    // Reset while source 2 is full; only the pre-reset broadcast appears.
    load(0, 3, 5); load(1, 3, 5); load(2, 3, 5); drive(); k = cyc;
    ex(2, 0, 5, 0, 0); ex(2, 1, 5, 1, 0);
    tick(); tick();
    chk("pre_reset_full2", 32'(src_ready[2]), 32'h0);
    reset = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) ph[i] = pt[i];
    drive();
    reset = 1'b0;
    chk("post_reset_valid", 32'(cdb_valid), 32'h0);
    chk("post_reset_ready", 32'(src_ready), 32'hf);

    // Priority restarts at source 0 after reset.
    load(2, 1, 6); load(0, 1, 6); drive(); k = cyc;
    ex(2, 0, 6, 0, 0); ex(2, 1, 6, 2, 0);
    repeat (6) tick();

    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
